// File: rtl/rfm_cnt_ctrl_pkg.sv
// Shared types, CAM port widths and helpers for the activation-count controller.
package rfm_cnt_ctrl_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned ENTRY_WIDTH = 7;
  localparam int unsigned ROW_NUM     = 68;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [ENTRY_WIDTH-1:0] idx_t;

  localparam word_t ALERT_TH  = 16'd1024;
  localparam idx_t  ROW_LIMIT = idx_t'(ROW_NUM);

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_MAX,
    ST_SRCH,
    ST_CLR,
    ST_ACK,
    ST_WCLR
  } state_t;

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + word_t'(1);
  endfunction

endpackage

// File: rtl/rfm_cnt_ctrl_if.sv
// CAM access bundle: master is the count controller, slave is the CAM.
interface rfm_cnt_ctrl_if;
  import rfm_cnt_ctrl_pkg::*;

  word_t cam_data_in;
  idx_t  cam_addr_in;
  logic  cam_read_en;
  logic  cam_write_en;
  logic  cam_search_en;
  logic  cam_reset;
  logic  cam_max_en;
  word_t cam_data_out;
  idx_t  cam_addr_out;
  logic  cam_match;
  word_t cam_max;

  modport master (
    output cam_data_in, cam_addr_in, cam_read_en, cam_write_en,
           cam_search_en, cam_reset, cam_max_en,
    input  cam_data_out, cam_addr_out, cam_match, cam_max
  );

  modport slave (
    input  cam_data_in, cam_addr_in, cam_read_en, cam_write_en,
           cam_search_en, cam_reset, cam_max_en,
    output cam_data_out, cam_addr_out, cam_match, cam_max
  );

endinterface

// File: rtl/rfm_cnt_ctrl_fsm.sv
// Sequencer for activate read-modify-write, RFM max/search/clear and window clears.
module rfm_cnt_ctrl_fsm
  import rfm_cnt_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   act_go,
  input  logic   rfm_req,
  input  logic   clr_pend,
  input  logic   hit,
  output state_t state
);

  // Idle priority: pending window clear, then RFM, then a legal activate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      unique case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (clr_pend)     state <= ST_WCLR;
          else if (rfm_req) state <= ST_MAX;
          else if (act_go)  state <= ST_RD;
        end
        ST_RD:   state <= ST_WR;
        ST_WR:   state <= ST_IDLE;
        ST_MAX:  state <= ST_SRCH;
        ST_SRCH: state <= hit ? ST_CLR : ST_ACK;
        ST_CLR:  state <= ST_ACK;
        ST_ACK:  state <= ST_IDLE;
        ST_WCLR: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: rtl/rfm_cnt_ctrl.sv
// Master-side controller for the per-bank activation-count CAM: counting,
// threshold alerts, RFM hottest-entry extraction and window clears.
module rfm_cnt_ctrl
  import rfm_cnt_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  act_valid,
  output logic  act_ready,
  input  idx_t  act_idx,
  output logic  act_err,
  output logic  alert,
  output idx_t  alert_idx,
  input  logic  rfm_req,
  output logic  rfm_ack,
  output logic  rfm_hit,
  output idx_t  rfm_idx,
  output word_t rfm_cnt,
  input  logic  win_clr,
  rfm_cnt_ctrl_if.master cam
);

  state_t state;
  logic   clr_pend;
  idx_t   idx_r;
  word_t  cnt_r;
  word_t  max_r;
  logic   act_fire;
  logic   idx_ok;
  logic   hit;
  word_t  inc_val;

  assign act_ready = (state == ST_IDLE) && !clr_pend && !rfm_req;
  assign act_fire  = act_valid && act_ready;
  assign idx_ok    = act_idx < ROW_LIMIT;
  assign hit       = cam.cam_match && (max_r != '0);
  assign inc_val   = sat_inc(cnt_r);

  rfm_cnt_ctrl_fsm u_fsm (
    .clk      (clk),
    .reset    (reset),
    .act_go   (act_fire && idx_ok),
    .rfm_req  (rfm_req),
    .clr_pend (clr_pend),
    .hit      (hit),
    .state    (state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_pend  <= 1'b0;
      act_err   <= 1'b0;
      alert     <= 1'b0;
      alert_idx <= '0;
      rfm_ack   <= 1'b0;
      rfm_hit   <= 1'b0;
      rfm_idx   <= '0;
      rfm_cnt   <= '0;
      idx_r     <= '0;
      cnt_r     <= '0;
      max_r     <= '0;
    end else begin
      // A new pulse during WCLR survives so it is served again afterwards.
      clr_pend <= win_clr || (clr_pend && (state != ST_WCLR));
      act_err  <= act_fire && !idx_ok;
      alert    <= (state == ST_WR) && (inc_val >= ALERT_TH);
      rfm_ack  <= (state == ST_CLR) || ((state == ST_SRCH) && !hit);
      if (act_fire)                                idx_r     <= act_idx;
      if (state == ST_RD)                          cnt_r     <= cam.cam_data_out;
      if ((state == ST_WR) && (inc_val >= ALERT_TH)) alert_idx <= idx_r;
      if (state == ST_MAX)                         max_r     <= cam.cam_max;
      if (state == ST_SRCH) begin
        rfm_hit <= hit;
        rfm_idx <= hit ? cam.cam_addr_out : '0;
        rfm_cnt <= hit ? max_r : '0;
      end
    end
  end

  // CAM strobes follow the state; a reset cycle suppresses every access but clear.
  always_comb begin
    cam.cam_read_en   = 1'b0;
    cam.cam_write_en  = 1'b0;
    cam.cam_search_en = 1'b0;
    cam.cam_max_en    = 1'b0;
    cam.cam_data_in   = '0;
    cam.cam_addr_in   = '0;
    cam.cam_reset     = (state == ST_INIT) || (state == ST_WCLR);
    if (!reset) begin
      case (state)
        ST_RD: begin
          cam.cam_read_en = 1'b1;
          cam.cam_addr_in = idx_r;
        end
        ST_WR: begin
          cam.cam_write_en = 1'b1;
          cam.cam_addr_in  = idx_r;
          cam.cam_data_in  = inc_val;
        end
        ST_MAX:  cam.cam_max_en = 1'b1;
        ST_SRCH: begin
          cam.cam_search_en = 1'b1;
          cam.cam_data_in   = max_r;
        end
        ST_CLR: begin
          cam.cam_write_en = 1'b1;
          cam.cam_addr_in  = rfm_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
